// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // 0 = core load/store, 1 = debug/DMA loader
    typedef logic owner_t;

    localparam owner_t c_owner_core  = 1'b0;
    localparam owner_t c_owner_debug = 1'b1;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input owner_t owner);
        return NUM_REQ'(1) << owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_rr_pick
// Brief    : Combinational round-robin picker with optional owner lock.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arb_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  owner_t             i_last,
    input  owner_t             i_owner,
    input  logic               i_locked,
    output logic               o_grant_valid,
    output owner_t             o_winner,
    output logic               o_lock_hold
);

    always_comb begin
        o_grant_valid = |i_req;
        o_winner      = c_owner_core;
        o_lock_hold   = 1'b0;
        // A locked owner that still requests keeps the memory and bypasses fairness
        if (i_locked && i_req[i_owner]) begin
            o_winner    = i_owner;
            o_lock_hold = 1'b1;
        end else begin
            case (i_req)
                2'b01:   o_winner = c_owner_core;
                2'b10:   o_winner = c_owner_debug;
                2'b11:   o_winner = ~i_last;
                default: o_winner = c_owner_core;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter sharing one single-port data memory between
//            the core (port 0) and the debug/DMA loader (port 1).
// Config   : DMEM_ARB_LOCK_EN - lets the owner hold the memory across transactions
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_REQ-1:0]                  lock_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  rvalid_o,
    output logic [DATA_WIDTH-1:0]               rdata_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_wdata_o,
    output logic                                mem_we_o,
    input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
    output logic                                busy_o
);

    arb_state_t              r_state;
    owner_t                  r_owner;
    owner_t                  r_last;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      r_rd_pending;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [ADDR_WIDTH-1:0]   r_addr_hold;
    logic [DATA_WIDTH-1:0]   r_wdata_hold;

    logic                    w_locked;
    logic                    w_grant_valid;
    owner_t                  w_winner;
    logic                    w_lock_hold;

    dmem_arb_rr_pick u_pick (
        .i_req         (req_i),
        .i_last        (r_last),
        .i_owner       (r_owner),
        .i_locked      (w_locked),
        .o_grant_valid (w_grant_valid),
        .o_winner      (w_winner),
        .o_lock_hold   (w_lock_hold)
    );

`ifdef DMEM_ARB_LOCK_EN
    logic r_locked;
    logic w_decide;

    assign w_decide = (r_state == IDLE) || (r_state == RESP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_locked <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_locked <= lock_i[r_owner];
        end else if (w_decide && r_locked && !req_i[r_owner]) begin
            r_locked <= 1'b0;
        end
    end

    assign w_locked = r_locked;
`else
    logic w_unused_lock;

    assign w_unused_lock = ^lock_i;
    assign w_locked      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_owner      <= c_owner_core;
            r_last       <= c_owner_debug;
            r_gnt        <= '0;
            r_rd_pending <= '0;
            r_rdata      <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    r_rd_pending <= '0;
                    if (w_grant_valid) begin
                        r_state <= ACCESS;
                        r_owner <= w_winner;
                        r_gnt   <= owner_onehot(w_winner);
                        if (!w_lock_hold) begin
                            r_last <= w_winner;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                    end
                end
                ACCESS: begin
                    r_state      <= RESP;
                    r_gnt        <= '0;
                    // Hold the address/data so the memory pins stay quiet during RESP
                    r_addr_hold  <= addr_i[r_owner];
                    r_wdata_hold <= wdata_i[r_owner];
                    if (!we_i[r_owner]) begin
                        r_rd_pending <= owner_onehot(r_owner);
                        r_rdata      <= mem_rdata_i;
                    end else begin
                        r_rd_pending <= '0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_gnt        <= '0;
                    r_rd_pending <= '0;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign rvalid_o    = r_rd_pending;
    assign rdata_o     = r_rdata;
    assign busy_o      = (r_state != IDLE);

    // Reset gates the write strobe directly so a mid-ACCESS reset cannot commit a write
    assign mem_we_o    = (r_state == ACCESS) && we_i[r_owner] && !rst_i;
    assign mem_addr_o  = (r_state == ACCESS) ? addr_i[r_owner]  : r_addr_hold;
    assign mem_wdata_o = (r_state == ACCESS) ? wdata_i[r_owner] : r_wdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a simple
//            async-read / clocked-write memory attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req, we, lock;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0]          gnt, rvalid;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic                mem_we;
    logic [DW-1:0]       mem_rdata;
    logic                busy;

    logic [DW-1:0]       mem [0:255];
    logic                pl_en;
    logic [7:0]          pl_idx;
    logic [DW-1:0]       pl_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .lock_i      (lock),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en)       mem[pl_idx]          <= pl_data;
        else if (mem_we) mem[mem_addr[9:2]]   <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_idx  = a[9:2];
        pl_data = d;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        rst   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [1:0]  exp_g2 [6];
        logic [1:0]  exp_g5 [5];
        logic [1:0]  glog   [8];
        int          gcyc   [8];
        int          ng;
        int          cnt    [2];
        int          idx    [2];
        int          nrd    [2];
        logic [AW-1:0] base [2];
        logic [DW-1:0] rd_exp0 [2];
        logic [DW-1:0] rd_exp1 [3];
        logic [1:0]  prev_g;

        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        preload(32'h10, 32'hDEAD_BEEF);
        preload(32'h30, 32'h0);
        preload(32'h40, 32'hA0A0_0001);
        preload(32'h44, 32'hA0A0_0002);
        preload(32'h48, 32'hA0A0_0003);
        preload(32'h50, 32'hB0B0_0001);
        preload(32'h54, 32'hB0B0_0002);

        // Reset values
        check_eq("rst gnt",       gnt,       2'b00);
        check_eq("rst rvalid",    rvalid,    2'b00);
        check_eq("rst rdata",     rdata,     32'h0);
        check_eq("rst mem_we",    mem_we,    1'b0);
        check_eq("rst mem_addr",  mem_addr,  32'h0);
        check_eq("rst mem_wdata", mem_wdata, 32'h0);
        check_eq("rst busy",      busy,      1'b0);
        rst = 1'b0;
        step();

        // Single port-0 read
        req = 2'b01; we = 2'b00; addr[0] = 32'h10;
        step();
        check_eq("t1 gnt",      gnt,      2'b01);
        check_eq("t1 mem_addr", mem_addr, 32'h10);
        check_eq("t1 mem_we",   mem_we,   1'b0);
        check_eq("t1 busy",     busy,     1'b1);
        step();
        check_eq("t1 rvalid",   rvalid,   2'b01);
        check_eq("t1 rdata",    rdata,    32'hDEAD_BEEF);
        check_eq("t1 gnt resp", gnt,      2'b00);
        check_eq("t1 addr hold", mem_addr, 32'h10);
        req = 2'b00;
        step();
        check_eq("t1 idle busy",   busy,   1'b0);
        check_eq("t1 idle rvalid", rvalid, 2'b00);
        check_eq("t1 rdata held",  rdata,  32'hDEAD_BEEF);

        // Both ports writing continuously: strict alternation every 2 cycles
        apply_reset();
        exp_g2 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        we = 2'b11;
        addr[0] = 32'h20; wdata[0] = 32'h11;
        addr[1] = 32'h24; wdata[1] = 32'h22;
        req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq($sformatf("t2 gnt c%0d", i),    gnt,    exp_g2[i]);
            check_eq($sformatf("t2 mem_we c%0d", i), mem_we, exp_g2[i] != 2'b00);
            check_eq($sformatf("t2 rvalid c%0d", i), rvalid, 2'b00);
        end
        req = 2'b00;
        step();
        check_eq("t2 busy",     busy,  1'b0);
        check_eq("t2 mem 0x20", mem[8], 32'h11);
        check_eq("t2 mem 0x24", mem[9], 32'h22);

        // Write by port 0 then read of the same word by port 1
        apply_reset();
        req = 2'b11; we = 2'b01;
        addr[0] = 32'h24; wdata[0] = 32'h55;
        addr[1] = 32'h24;
        step();
        check_eq("t3 gnt p0",   gnt,       2'b01);
        check_eq("t3 mem_we",   mem_we,    1'b1);
        check_eq("t3 wdata",    mem_wdata, 32'h55);
        step();
        req = 2'b10;
        check_eq("t3 rvalid wr", rvalid,   2'b00);
        step();
        check_eq("t3 gnt p1",   gnt,       2'b10);
        check_eq("t3 rd we",    mem_we,    1'b0);
        step();
        check_eq("t3 rvalid",   rvalid,    2'b10);
        check_eq("t3 rdata",    rdata,     32'h55);
        req = 2'b00;
        step();
        check_eq("t3 busy",     busy,      1'b0);

        // Reset asserted in the middle of a write ACCESS
        apply_reset();
        req = 2'b01; we = 2'b01; addr[0] = 32'h30; wdata[0] = 32'h77;
        step();
        check_eq("t4 mem_we pre", mem_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("t4 mem_we rst",   mem_we,   1'b0);
        check_eq("t4 gnt rst",      gnt,      2'b00);
        check_eq("t4 busy rst",     busy,     1'b0);
        check_eq("t4 mem_addr rst", mem_addr, 32'h0);
        req = 2'b00;
        step();
        rst = 1'b0;
        step();
        check_eq("t4 mem 0x30", mem[12], 32'h0);
        check_eq("t4 rvalid",   rvalid,  2'b00);

        // Port 1 issues 3 reads with lock, port 0 joins with 2 reads
        apply_reset();
`ifdef DMEM_ARB_LOCK_EN
        exp_g5 = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
`else
        exp_g5 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rd_exp0 = '{32'hB0B0_0001, 32'hB0B0_0002};
        rd_exp1 = '{32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        base[0] = 32'h50; base[1] = 32'h40;
        cnt[0] = 2; cnt[1] = 3;
        idx[0] = 0; idx[1] = 0;
        nrd[0] = 0; nrd[1] = 0;
        ng = 0; prev_g = 2'b00;
        we = 2'b00;
        addr[0] = base[0]; addr[1] = base[1];
        lock = 2'b10;
        req  = 2'b10;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rvalid[0]) begin
                if (nrd[0] < 2) check_eq($sformatf("t5 p0 rdata %0d", nrd[0]), rdata, rd_exp0[nrd[0]]);
                nrd[0]++;
            end
            if (rvalid[1]) begin
                if (nrd[1] < 3) check_eq($sformatf("t5 p1 rdata %0d", nrd[1]), rdata, rd_exp1[nrd[1]]);
                nrd[1]++;
            end
            for (int n = 0; n < 2; n++) begin
                if (prev_g[n]) begin
                    cnt[n]--;
                    idx[n]++;
                    addr[n] = base[n] + AW'(4 * idx[n]);
                end
                req[n] = (cnt[n] > 0);
            end
            lock[1] = (cnt[1] > 1);
            if (gnt != 2'b00 && ng < 8) begin
                glog[ng] = gnt;
                gcyc[ng] = c;
                ng++;
            end
            prev_g = gnt;
        end
        check_eq("t5 grant count", ng, 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                check_eq($sformatf("t5 gnt %0d", k),   glog[k], exp_g5[k]);
                check_eq($sformatf("t5 cycle %0d", k), gcyc[k], 2 * k);
            end
        end
        check_eq("t5 p0 reads", nrd[0], 2);
        check_eq("t5 p1 reads", nrd[1], 3);
        check_eq("t5 busy",     busy,   1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
